// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its PLL / downstream consumers.
// master: the sequencer side. slave: the PLL and core-reset consumers.
interface pll_reset_sequencer_if;
    logic       locked_in;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic [7:0] relock_count;
    logic [7:0] timeout_count;
    logic       timeout_err;

    modport master (
        input  locked_in,
        output pll_rst,
        output core_reset,
        output ready,
        output relock_count,
        output timeout_count,
        output timeout_err
    );

    modport slave (
        output locked_in,
        input  pll_rst,
        input  core_reset,
        input  ready,
        input  relock_count,
        input  timeout_count,
        input  timeout_err
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock, lets the lock settle,
// then releases the core reset. Lock losses and lock timeouts are counted.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_PLL_RST   | pll_rst held high for RST_PULSE cycles
// S_WAIT_LOCK | waiting for synchronized lock, retry after LOCK_TIMEOUT
// S_SETTLE    | lock must stay high SETTLE_CYCLES in a row
// S_RUN       | core released; DROP_FILTER low cycles in a row = lock lost
module pll_reset_sequencer #(
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int SETTLE_CYCLES = 1024,
    parameter int DROP_FILTER   = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                   refclk,
    input  logic                   rst,
    pll_reset_sequencer_if.master  bus
);

    localparam int MAX_A   = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int MAX_B   = (RST_PULSE > DROP_FILTER) ? RST_PULSE : DROP_FILTER;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // cnt never exceeds CNT_MAX-1, so clog2(CNT_MAX) bits suffice
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DROP_LAST   = CNT_W'(DROP_FILTER - 1);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_SETTLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   timeout_d;
    logic                   relock_d;

    logic                   pll_rst_q;
    logic                   core_reset_q;
    logic                   ready_q;
    logic                   timeout_err_q;
    logic [7:0]             relock_count_q;
    logic [7:0]             timeout_count_q;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous PLL lock into the refclk domain
    always_ff @(posedge refclk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked_in};
    end

    // Next-state and shared counter decode; any transition clears the counter
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        timeout_d = 1'b0;
        relock_d  = 1'b0;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                // lock has priority over a timeout landing on the same cycle
                if (locked_s) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d   = S_PLL_RST;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                // cnt tracks the length of the current dropout
                if (locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == DROP_LAST) begin
                    state_d  = S_WAIT_LOCK;
                    cnt_d    = '0;
                    relock_d = 1'b1;
                end
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs decoded from the next state
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q         <= S_PLL_RST;
            cnt_q           <= '0;
            pll_rst_q       <= 1'b1;
            core_reset_q    <= 1'b1;
            ready_q         <= 1'b0;
            timeout_err_q   <= 1'b0;
            relock_count_q  <= 8'd0;
            timeout_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pll_rst_q     <= (state_d == S_PLL_RST);
            core_reset_q  <= (state_d != S_RUN);
            ready_q       <= (state_d == S_RUN);
            timeout_err_q <= timeout_d;
            if (relock_d && (relock_count_q != 8'hFF))
                relock_count_q <= relock_count_q + 8'd1;
            if (timeout_d && (timeout_count_q != 8'hFF))
                timeout_count_q <= timeout_count_q + 8'd1;
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.core_reset    = core_reset_q;
    assign bus.ready         = ready_q;
    assign bus.timeout_err   = timeout_err_q;
    assign bus.relock_count  = relock_count_q;
    assign bus.timeout_count = timeout_count_q;

endmodule
